// File: rtl/esvaziamento_caixa.sv
// Outlet-side drain controller: opens Valve_S until the requested volume (in TICK_DIV-cycle units) is delivered.
// Latency: valve opens on the edge after req is accepted; all outputs are registered, with no input-to-output paths.
// Backpressure: erro pauses draining (no metering is lost), lower parks in EMPTY until abort; build option DRAIN_LEVEL_GUARD_EN.
`timescale 1ns/1ps
module esvaziamento_caixa #(
    parameter int VOL_W     = 4,
    parameter int TICK_DIV  = 4,
    parameter int MIN_LEVEL = 1
) (
`ifdef DRAIN_LEVEL_GUARD_EN
    input  logic [2:0]       level,
`endif
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic [VOL_W-1:0] volume,
    input  logic             abort,
    input  logic             lower,
    input  logic             erro,
    output logic             Valve_S,
    output logic [VOL_W-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             fault_empty
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_PAUSE,
        S_DONE,
        S_EMPTY
    } state_t;

    state_t             state, state_nxt;
    logic [TICK_W-1:0]  tick, tick_nxt, tick_adv;
    logic [VOL_W-1:0]   rem, rem_nxt;
    logic               low_stop;
    logic               unit_end;
    logic               last_unit;

`ifdef DRAIN_LEVEL_GUARD_EN
    assign low_stop = lower | (level <= 3'(MIN_LEVEL));
`else
    assign low_stop = lower;
`endif

    assign unit_end  = (tick == TICK_LAST);
    assign last_unit = unit_end && (rem == VOL_W'(1));
    assign tick_adv  = unit_end ? '0 : tick + TICK_W'(1);

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick;
        rem_nxt   = rem;
        case (state)
            S_IDLE: begin
                if (!abort && !erro && req) begin
                    if (volume == '0) begin
                        state_nxt = S_DONE;
                    end else if (low_stop) begin
                        state_nxt = S_EMPTY;
                    end else begin
                        state_nxt = S_DRAIN;
                        rem_nxt   = volume;
                        tick_nxt  = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    rem_nxt   = '0;
                    tick_nxt  = '0;
                end else if (low_stop && !erro) begin
                    state_nxt = S_EMPTY;
                    tick_nxt  = '0;
                end else begin
                    // The cycle just ending had the valve open, so it is metered
                    // even when erro parks us in PAUSE on this edge.
                    tick_nxt = tick_adv;
                    if (unit_end) begin
                        rem_nxt = rem - VOL_W'(1);
                    end
                    if (last_unit) begin
                        state_nxt = S_DONE;
                    end else if (erro) begin
                        state_nxt = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    rem_nxt   = '0;
                    tick_nxt  = '0;
                end else if (!erro) begin
                    if (low_stop) begin
                        state_nxt = S_EMPTY;
                        tick_nxt  = '0;
                    end else begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                rem_nxt   = '0;
                tick_nxt  = '0;
            end
            S_EMPTY: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    rem_nxt   = '0;
                    tick_nxt  = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                rem_nxt   = '0;
                tick_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            tick        <= '0;
            rem         <= '0;
            Valve_S     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault_empty <= 1'b0;
        end else begin
            state       <= state_nxt;
            tick        <= tick_nxt;
            rem         <= rem_nxt;
            Valve_S     <= (state_nxt == S_DRAIN);
            busy        <= (state_nxt == S_DRAIN) || (state_nxt == S_PAUSE);
            done        <= (state_nxt == S_DONE);
            fault_empty <= (state_nxt == S_EMPTY);
        end
    end

    assign remaining = rem;

endmodule

// File: tb/tb_esvaziamento_caixa.sv
// Scoreboard bench for esvaziamento_caixa: per-cycle output checks plus open-valve cycle counts per completed transfer.
`timescale 1ns/1ps
module tb_esvaziamento_caixa;
    localparam int VOL_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req = 1'b0;
    logic [VOL_W-1:0] volume = '0;
    logic             abort = 1'b0;
    logic             lower = 1'b0;
    logic             erro = 1'b0;
    logic             Valve_S;
    logic [VOL_W-1:0] remaining;
    logic             busy;
    logic             done;
    logic             fault_empty;
`ifdef DRAIN_LEVEL_GUARD_EN
    logic [2:0]       level = 3'd7;
`endif

    wire [VOL_W+3:0] obs = {Valve_S, remaining, busy, done, fault_empty};

    int n_cmp = 0;
    int n_err = 0;
    int open_cnt = 0;
    int sb[$];

    esvaziamento_caixa #(.VOL_W(VOL_W), .TICK_DIV(4), .MIN_LEVEL(1)) dut (
`ifdef DRAIN_LEVEL_GUARD_EN
        .level(level),
`endif
        .clock(clock),
        .reset(reset),
        .req(req),
        .volume(volume),
        .abort(abort),
        .lower(lower),
        .erro(erro),
        .Valve_S(Valve_S),
        .remaining(remaining),
        .busy(busy),
        .done(done),
        .fault_empty(fault_empty)
    );

    always #5 clock = ~clock;

    // Count open-valve cycles per transfer; each done pulse is matched against the queue.
    always @(negedge clock) begin
        if (!reset) begin
            open_cnt = 0;
        end else begin
            if (Valve_S === 1'b1) open_cnt++;
            if (done === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected_done got=done_pulse exp=no_transfer_pending");
                end else begin
                    int e;
                    e = sb.pop_front();
                    if (open_cnt != e) begin
                        n_err++;
                        $display("FAIL sb_open_cycles got=%0d exp=%0d", open_cnt, e);
                    end
                end
                open_cnt = 0;
            end
            if (fault_empty === 1'b1) open_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s got=no_done exp=done_within_100_cycles", name);
        end
        step();
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        req = 1'b1;
        volume = 4'd3;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if (obs !== '0) begin
                n_err++;
                $display("FAIL reset_hold c=%0d got=%h exp=0", c, obs);
            end
        end
        reset = 1'b1;
        sb.push_back(12);
        step();
        req = 1'b0;
        n_cmp++;
        if (obs !== {1'b1, 4'd3, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_release got=%h exp=%h", obs, {1'b1, 4'd3, 1'b1, 1'b0, 1'b0});
        end
        wait_done("reset_release_done");
    endtask

    task automatic test_basic();
        logic [VOL_W+3:0] exp;
        logic v, d;
        logic [VOL_W-1:0] r;
        req = 1'b1;
        volume = 4'd3;
        sb.push_back(12);
        for (int c = 0; c <= 13; c++) begin
            step();
            if (c == 0) req = 1'b0;
            v = (c <= 11);
            d = (c == 12);
            r = (c < 4) ? 4'd3 : (c < 8) ? 4'd2 : (c < 12) ? 4'd1 : 4'd0;
            exp = {v, r, v, d, 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL basic_vol3 c=%0d got=%h exp=%h", c, obs, exp);
            end
        end
    endtask

    task automatic test_pause();
        logic [VOL_W+3:0] exp;
        logic v;
        logic [VOL_W-1:0] r;
        req = 1'b1;
        volume = 4'd3;
        sb.push_back(12);
        for (int c = 0; c <= 9; c++) begin
            step();
            v = (c <= 1) || (c >= 7);
            r = (c <= 8) ? 4'd3 : 4'd2;
            exp = {v, r, 1'b1, 1'b0, 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL pause c=%0d got=%h exp=%h", c, obs, exp);
            end
            if (c == 0) req = 1'b0;
            if (c == 1) erro = 1'b1;
            if (c == 6) erro = 1'b0;
        end
        wait_done("pause_done");
    endtask

    task automatic test_empty();
        logic [VOL_W+3:0] exp;
        req = 1'b1;
        volume = 4'd3;
        for (int c = 0; c <= 5; c++) begin
            step();
            if (c < 5) exp = {1'b1, (c < 4) ? 4'd3 : 4'd2, 1'b1, 1'b0, 1'b0};
            else       exp = {1'b0, 4'd2, 1'b0, 1'b0, 1'b1};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL empty_entry c=%0d got=%h exp=%h", c, obs, exp);
            end
            if (c == 0) req = 1'b0;
            if (c == 4) lower = 1'b1;
        end
        lower = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if (obs !== {1'b0, 4'd2, 1'b0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL empty_hold c=%0d got=%h exp=%h", c, obs, {1'b0, 4'd2, 1'b0, 1'b0, 1'b1});
            end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL empty_abort got=%h exp=0", obs);
        end
    endtask

    task automatic test_zero();
        req = 1'b1;
        volume = 4'd0;
        sb.push_back(0);
        step();
        req = 1'b0;
        n_cmp++;
        if (obs !== {1'b0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL zero_done got=%h exp=%h", obs, {1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
        end
        step();
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL zero_idle got=%h exp=0", obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [VOL_W+3:0] exp;
        logic v;
        req = 1'b1;
        volume = 4'd1;
        sb.push_back(4);
        sb.push_back(4);
        for (int c = 0; c <= 6; c++) begin
            step();
            v = (c <= 3) || (c == 6);
            exp = {v, v ? 4'd1 : 4'd0, v, (c == 4), 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs, exp);
            end
        end
        req = 1'b0;
        wait_done("back_to_back_done");
    endtask

    task automatic test_erro_ignored();
        erro = 1'b1;
        req = 1'b1;
        volume = 4'd2;
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++;
            if (obs !== '0) begin
                n_err++;
                $display("FAIL erro_ignored c=%0d got=%h exp=0", c, obs);
            end
        end
        erro = 1'b0;
        req = 1'b0;
    endtask

    task automatic test_reset_mid();
        req = 1'b1;
        volume = 4'd3;
        step();
        req = 1'b0;
        for (int c = 0; c < 4; c++) step();
        n_cmp++;
        if (obs !== {1'b1, 4'd2, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid_pre got=%h exp=%h", obs, {1'b1, 4'd2, 1'b1, 1'b0, 1'b0});
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_mid_async got=%h exp=0", obs);
        end
        step();
        reset = 1'b1;
        step();
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_mid_restart got=%h exp=0", obs);
        end
    endtask

`ifdef DRAIN_LEVEL_GUARD_EN
    task automatic test_level_guard();
        level = 3'd1;
        req = 1'b1;
        volume = 4'd3;
        for (int c = 0; c < 2; c++) begin
            step();
            req = 1'b0;
            n_cmp++;
            if (obs !== {1'b0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL level_guard c=%0d got=%h exp=%h", c, obs, {1'b0, 4'd0, 1'b0, 1'b0, 1'b1});
            end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        level = 3'd7;
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL level_guard_abort got=%h exp=0", obs);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_empty();
        test_zero();
        test_back_to_back();
        test_erro_ignored();
        test_reset_mid();
`ifdef DRAIN_LEVEL_GUARD_EN
        test_level_guard();
`endif
        step();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
